// File: rtl/hssi_rx_pkt_pkg.sv
// Shared types for the HSSI RX packet buffer: stored beat layout, FSM encoding
// and pointer sizing.
package hssi_rx_pkt_pkg;

  localparam int RX_TDATA_WIDTH = 512;

  typedef struct packed {
    logic [RX_TDATA_WIDTH-1:0] data;
    logic                      last;
    logic                      user;
  } rx_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    DROP   = 2'd2
  } rx_state_e;

  // One extra pointer bit distinguishes full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hssi_rx_pkt_buf_if.sv
// MAC RX AVST input and AXI-S output of the RX packet buffer.
// master = the buffer itself; slave = the MAC/AFU environment around it.
interface hssi_rx_pkt_buf_if #(
  parameter int TDATA_WIDTH = 512
);
  logic                   s_valid;
  logic [TDATA_WIDTH-1:0] s_data;
  logic                   s_sop;
  logic                   s_eop;
  logic                   s_error;

  logic                   m_ready;
  logic                   m_valid;
  logic [TDATA_WIDTH-1:0] m_data;
  logic                   m_last;
  logic                   m_user;

  modport master (
    input  s_valid, s_data, s_sop, s_eop, s_error, m_ready,
    output m_valid, m_data, m_last, m_user
  );

  modport slave (
    output s_valid, s_data, s_sop, s_eop, s_error, m_ready,
    input  m_valid, m_data, m_last, m_user
  );
endinterface

// File: rtl/hssi_rx_sdp_ram.sv
// Simple dual-port beat store with one-cycle registered read.
// The read register holds its value while rd_en is low and serves as the output holding stage.
module hssi_rx_sdp_ram
  import hssi_rx_pkt_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  rx_entry_t                wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output rx_entry_t                rd_data
);

  rx_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/hssi_rx_pkt_buf.sv
// Store-and-forward RX packet buffer: no-backpressure MAC AVST in, AXI-S out.
// Packets that do not fit are dropped whole; drops and framing faults are counted.
module hssi_rx_pkt_buf
  import hssi_rx_pkt_pkg::*;
#(
  parameter int TDATA_WIDTH = RX_TDATA_WIDTH,
  parameter int DEPTH       = 512,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hssi_rx_pkt_buf_if.master    bus,
  output logic [CNT_WIDTH-1:0] ovf_drop_cnt,
  output logic [CNT_WIDTH-1:0] frame_err_cnt
);

  localparam int            PW        = ptr_width(DEPTH);
  localparam int            AW        = PW - 1;
  localparam logic [PW-1:0] DEPTH_P   = PW'(DEPTH);
  localparam logic [1:0]    ST_IDLE   = IDLE;
  localparam logic [1:0]    ST_ACCEPT = ACCEPT;
  localparam logic [1:0]    ST_DROP   = DROP;

  logic [1:0]    state, nxt_state;
  logic [PW-1:0] wr_ptr, cmt_ptr, rd_ptr;
  logic [PW-1:0] nxt_wr, nxt_cmt, base_p0;
  logic          wr_en_p0, rd_en_p0, vld_p1;
  logic          ovf_inc, ferr_inc;
  rx_entry_t     wr_entry_p0, rd_entry_p1;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic                 inc);
    return (inc && (cnt != '1)) ? cnt + CNT_WIDTH'(1) : cnt;
  endfunction

  always_comb begin
    wr_entry_p0.data = bus.s_data[TDATA_WIDTH-1:0];
    wr_entry_p0.last = bus.s_eop;
    wr_entry_p0.user = bus.s_error & bus.s_eop;
  end

  // Stage p0: framing FSM and write admission. Any sop restarts from the committed pointer.
  always_comb begin
    nxt_state = state;
    nxt_wr    = wr_ptr;
    nxt_cmt   = cmt_ptr;
    wr_en_p0  = 1'b0;
    ovf_inc   = 1'b0;
    ferr_inc  = 1'b0;
    base_p0   = (state == ST_ACCEPT && !bus.s_sop) ? wr_ptr : cmt_ptr;
    if (bus.s_valid) begin
      if (state == ST_DROP && !bus.s_sop) begin
        if (bus.s_eop) nxt_state = ST_IDLE;
      end else if (state != ST_ACCEPT && !bus.s_sop) begin
        ferr_inc = 1'b1;
      end else begin
        if (state != ST_IDLE && bus.s_sop) ferr_inc = 1'b1;
        if ((base_p0 - rd_ptr) == DEPTH_P) begin
          ovf_inc   = 1'b1;
          nxt_wr    = cmt_ptr;
          nxt_state = bus.s_eop ? ST_IDLE : ST_DROP;
        end else begin
          wr_en_p0  = 1'b1;
          nxt_wr    = base_p0 + PW'(1);
          if (bus.s_eop) begin
            nxt_cmt   = base_p0 + PW'(1);
            nxt_state = ST_IDLE;
          end else begin
            nxt_state = ST_ACCEPT;
          end
        end
      end
    end
  end

  // Read into the holding stage whenever it is empty or being consumed this cycle.
  assign rd_en_p0 = (cmt_ptr != rd_ptr) && (!vld_p1 || bus.m_ready);

  hssi_rx_sdp_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en_p0),
    .wr_addr (base_p0[AW-1:0]),
    .wr_data (wr_entry_p0),
    .rd_en   (rd_en_p0),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_entry_p1)
  );

  // Stage p1: registered first-word-fall-through output.
  assign bus.m_valid = vld_p1;
  assign bus.m_data  = rd_entry_p1.data;
  assign bus.m_last  = rd_entry_p1.last;
  assign bus.m_user  = rd_entry_p1.user;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      wr_ptr        <= '0;
      cmt_ptr       <= '0;
      rd_ptr        <= '0;
      vld_p1        <= 1'b0;
      ovf_drop_cnt  <= '0;
      frame_err_cnt <= '0;
    end else begin
      state         <= nxt_state;
      wr_ptr        <= nxt_wr;
      cmt_ptr       <= nxt_cmt;
      if (rd_en_p0) rd_ptr <= rd_ptr + PW'(1);
      vld_p1        <= rd_en_p0 | (vld_p1 & ~bus.m_ready);
      ovf_drop_cnt  <= sat_inc(ovf_drop_cnt, ovf_inc);
      frame_err_cnt <= sat_inc(frame_err_cnt, ferr_inc);
    end
  end

endmodule

// File: tb/tb_hssi_rx_pkt_buf.sv
// Directed bench for hssi_rx_pkt_buf (DEPTH=8): ordering, latency, overflow drop,
// framing errors, output stall stability and asynchronous reset.
module tb_hssi_rx_pkt_buf;

  typedef struct packed {
    logic [511:0] d;
    logic         l;
    logic         u;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] ovf_drop_cnt;
  logic [15:0] frame_err_cnt;
  int          errors;
  int          checks;
  beat_t       rxq[$];

  hssi_rx_pkt_buf_if #(.TDATA_WIDTH(512)) bus ();

  hssi_rx_pkt_buf #(
    .TDATA_WIDTH (512),
    .DEPTH       (8),
    .CNT_WIDTH   (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .ovf_drop_cnt  (ovf_drop_cnt),
    .frame_err_cnt (frame_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted output beats, sampled mid-cycle ahead of the handshake edge.
  always @(negedge clk) begin
    if (bus.m_valid && bus.m_ready) rxq.push_back({bus.m_data, bus.m_last, bus.m_user});
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic sop, input logic eop, input logic err);
    bus.s_valid = 1'b1;
    bus.s_data  = 512'(d);
    bus.s_sop   = sop;
    bus.s_eop   = eop;
    bus.s_error = err;
    cyc();
    bus.s_valid = 1'b0;
    bus.s_sop   = 1'b0;
    bus.s_eop   = 1'b0;
    bus.s_error = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    rxq.delete();
  endtask

  task automatic chk_stream(input string tag, input int n, input int d0, input int plen);
    chk({tag, ".count"}, 512'(rxq.size()), 512'(n));
    for (int i = 0; i < n && i < rxq.size(); i++) begin
      chk($sformatf("%s.data%0d", tag, i), rxq[i].d, 512'(d0 + i));
      chk($sformatf("%s.last%0d", tag, i), 512'(rxq[i].l), 512'((i % plen) == (plen - 1)));
      chk($sformatf("%s.user%0d", tag, i), 512'(rxq[i].u), 512'(0));
    end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_sop   = 1'b0;
    bus.s_eop   = 1'b0;
    bus.s_error = 1'b0;
    bus.m_ready = 1'b0;
    cyc();
    cyc();
    chk("rst.m_valid", 512'(bus.m_valid), 512'(0));
    chk("rst.m_data", bus.m_data, 512'(0));
    chk("rst.m_last", 512'(bus.m_last), 512'(0));
    chk("rst.m_user", 512'(bus.m_user), 512'(0));
    chk("rst.ovf_cnt", 512'(ovf_drop_cnt), 512'(0));
    chk("rst.ferr_cnt", 512'(frame_err_cnt), 512'(0));
    rst_n = 1'b1;
    cyc();

    // Three 4-beat packets back to back, sink always ready.
    bus.m_ready = 1'b1;
    for (int k = 1; k <= 4; k++) send(k, (k % 4) == 1, (k % 4) == 0, 1'b0);
    chk("t1.lat_eop_plus1", 512'(bus.m_valid), 512'(0));
    send(5, 1'b1, 1'b0, 1'b0);
    chk("t1.lat_eop_plus2.valid", 512'(bus.m_valid), 512'(1));
    chk("t1.lat_eop_plus2.data", bus.m_data, 512'(1));
    for (int k = 6; k <= 12; k++) send(k, (k % 4) == 1, (k % 4) == 0, 1'b0);
    repeat (12) cyc();
    chk_stream("t1", 12, 1, 4);
    chk("t1.ovf_cnt", 512'(ovf_drop_cnt), 512'(0));
    chk("t1.ferr_cnt", 512'(frame_err_cnt), 512'(0));

    // Overflow: 6-beat packet parked, 4-beat packet cannot fit.
    do_reset();
    bus.m_ready = 1'b0;
    for (int k = 0; k < 6; k++) send(21 + k, k == 0, k == 5, 1'b0);
    for (int k = 0; k < 4; k++) send(31 + k, k == 0, k == 3, 1'b0);
    cyc();
    chk("t2.ovf_cnt", 512'(ovf_drop_cnt), 512'(1));
    chk("t2.ferr_cnt", 512'(frame_err_cnt), 512'(0));
    chk("t2.stall.valid", 512'(bus.m_valid), 512'(1));
    chk("t2.stall.data", bus.m_data, 512'(21));
    bus.m_ready = 1'b1;
    repeat (12) cyc();
    chk_stream("t2", 6, 21, 6);

    // Missing eop: the first fragment is abandoned on the second sop.
    do_reset();
    bus.m_ready = 1'b1;
    send(91, 1'b1, 1'b0, 1'b0);
    send(92, 1'b0, 1'b0, 1'b0);
    send(41, 1'b1, 1'b0, 1'b0);
    send(42, 1'b0, 1'b0, 1'b0);
    send(43, 1'b0, 1'b1, 1'b0);
    repeat (8) cyc();
    chk("t3.ferr_cnt", 512'(frame_err_cnt), 512'(1));
    chk("t3.ovf_cnt", 512'(ovf_drop_cnt), 512'(0));
    chk_stream("t3", 3, 41, 3);

    // Beat without sop while idle.
    do_reset();
    bus.m_ready = 1'b1;
    send(61, 1'b0, 1'b0, 1'b0);
    repeat (4) cyc();
    chk("t4.ferr_cnt", 512'(frame_err_cnt), 512'(1));
    chk("t4.m_valid", 512'(bus.m_valid), 512'(0));
    chk("t4.count", 512'(rxq.size()), 512'(0));

    // Single-beat errored packet with a stalling sink.
    do_reset();
    bus.m_ready = 1'b1;
    send(55, 1'b1, 1'b1, 1'b1);
    chk("t5.early.valid", 512'(bus.m_valid), 512'(0));
    cyc();
    bus.m_ready = 1'b0;
    chk("t5.valid", 512'(bus.m_valid), 512'(1));
    chk("t5.data", bus.m_data, 512'(55));
    chk("t5.last", 512'(bus.m_last), 512'(1));
    chk("t5.user", 512'(bus.m_user), 512'(1));
    cyc();
    chk("t5.hold.valid", 512'(bus.m_valid), 512'(1));
    chk("t5.hold.data", bus.m_data, 512'(55));
    chk("t5.hold.user", 512'(bus.m_user), 512'(1));
    bus.m_ready = 1'b1;
    cyc();
    bus.m_ready = 1'b0;
    chk("t5.after.valid", 512'(bus.m_valid), 512'(0));
    cyc();
    bus.m_ready = 1'b1;
    cyc();
    chk("t5.count", 512'(rxq.size()), 512'(1));
    if (rxq.size() > 0) begin
      chk("t5.out.data", rxq[0].d, 512'(55));
      chk("t5.out.last", 512'(rxq[0].l), 512'(1));
      chk("t5.out.user", 512'(rxq[0].u), 512'(1));
    end

    // Asynchronous reset with a stored packet and a partial one in flight.
    do_reset();
    bus.m_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(81 + k, k == 0, k == 3, 1'b0);
    send(85, 1'b1, 1'b0, 1'b0);
    send(86, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("t6.pre.valid", 512'(bus.m_valid), 512'(1));
    chk("t6.pre.data", bus.m_data, 512'(81));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6.async.valid", 512'(bus.m_valid), 512'(0));
    chk("t6.async.data", bus.m_data, 512'(0));
    cyc();
    cyc();
    rst_n = 1'b1;
    rxq.delete();
    bus.m_ready = 1'b1;
    send(71, 1'b1, 1'b0, 1'b0);
    send(72, 1'b0, 1'b0, 1'b0);
    send(73, 1'b0, 1'b1, 1'b0);
    repeat (8) cyc();
    chk_stream("t6", 3, 71, 3);
    chk("t6.ovf_cnt", 512'(ovf_drop_cnt), 512'(0));
    chk("t6.ferr_cnt", 512'(frame_err_cnt), 512'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
